// File: rtl/ex3_pkg.sv
// Shared constants for the Excess-3 to BCD deserializer: code range, offset and FSM encoding.
package ex3_pkg;

  localparam logic [3:0] EX3_OFFSET = 4'd3;
  localparam logic [3:0] EX3_MIN    = 4'd3;
  localparam logic [3:0] EX3_MAX    = 4'd12;

  typedef logic state_t;

  localparam state_t COLLECT = 1'b0;
  localparam state_t HOLD    = 1'b1;

endpackage

// File: rtl/ex3_digit_decode.sv
// Combinational Excess-3 digit decoder; out-of-range codes decode to zero and raise invalid.
module ex3_digit_decode
  import ex3_pkg::*;
(
  input  logic [3:0] ex3,
  output logic [3:0] bcd,
  output logic       invalid
);

  assign invalid = (ex3 < EX3_MIN) || (ex3 > EX3_MAX);
  assign bcd     = invalid ? 4'h0 : (ex3 - EX3_OFFSET);

endmodule

// File: rtl/ex3_to_bcd_deserializer.sv
// Packs NDIGITS Excess-3 digits (MS digit first) into one BCD word with a sticky error flag.
// Optional saturating invalid-digit counter on err_cnt when EX3_ERR_COUNT_EN is defined.
module ex3_to_bcd_deserializer
  import ex3_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_ex3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] out_bcd,
  output logic                 out_err
`ifdef EX3_ERR_COUNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int CW = $clog2(NDIGITS + 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [4*NDIGITS-1:0] shreg;
  logic [4*NDIGITS-1:0] shift_next;
  logic                 err_acc;
  logic                 started;
  logic [3:0]           dec_bcd;
  logic                 dec_inv;
  logic                 accept;
  logic                 last;

  ex3_digit_decode u_dec (
    .ex3     (in_ex3),
    .bcd     (dec_bcd),
    .invalid (dec_inv)
  );

  // A single-digit word has nothing to shift in from below.
  if (NDIGITS == 1) begin : g_one
    assign shift_next = dec_bcd;
  end else begin : g_many
    assign shift_next = {shreg[4*NDIGITS-5:0], dec_bcd};
  end

  // in_ready is held low until the first edge after reset release.
  assign in_ready  = started && (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign out_bcd   = shreg;
  assign out_err   = err_acc;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(NDIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      cnt     <= '0;
      shreg   <= '0;
      err_acc <= 1'b0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (state == COLLECT) begin
        if (accept) begin
          shreg <= shift_next;
          if (dec_inv) err_acc <= 1'b1;
          if (last) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end else if (out_ready) begin
        state   <= COLLECT;
        shreg   <= '0;
        err_acc <= 1'b0;
      end
    end
  end

`ifdef EX3_ERR_COUNT_EN
  // Counts every accepted invalid digit since reset; word consumption does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (accept && dec_inv && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex3_to_bcd_deserializer.sv
// Self-checking bench for ex3_to_bcd_deserializer (NDIGITS=4); covers err_cnt when EX3_ERR_COUNT_EN is defined.
module tb_ex3_to_bcd_deserializer;

  localparam int NDIGITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_ex3 = 4'h0;
  logic        in_ready;
  logic        out_valid;
  logic        out_err;
  logic [15:0] out_bcd;
`ifdef EX3_ERR_COUNT_EN
  logic [7:0]  err_cnt;
  int          inv_total = 0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex3_to_bcd_deserializer #(.NDIGITS(NDIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ex3    (in_ex3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err)
`ifdef EX3_ERR_COUNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each code maps to its decimal value minus three; out-of-range codes give 0 and flag the word.
  function automatic logic [16:0] model_word(input logic [15:0] codes);
    int   w = 0;
    logic e = 1'b0;
    int   c;
    for (int i = 3; i >= 0; i--) begin
      c = int'(codes[4*i +: 4]);
      if (c >= 3 && c <= 12) begin
        w = w * 16 + (c - 3);
      end else begin
        w = w * 16;
        e = 1'b1;
      end
    end
    return {e, w[15:0]};
  endfunction

  function automatic int n_invalid(input logic [15:0] codes);
    int n = 0;
    int c;
    for (int i = 0; i < 4; i++) begin
      c = int'(codes[4*i +: 4]);
      if (c < 3 || c > 12) n++;
    end
    return n;
  endfunction

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_digit(input logic [3:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_ex3   = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_ex3   = 4'($urandom);
  endtask

  task automatic send_word(input logic [15:0] codes, input int gap);
    for (int i = 3; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_ex3   = 4'($urandom);
        @(negedge clk);
      end
      send_digit(codes[4*i +: 4]);
    end
`ifdef EX3_ERR_COUNT_EN
    inv_total += n_invalid(codes);
`endif
  endtask

  task automatic expect_word(input string tag, input logic [15:0] codes, input int hold);
    logic [16:0] m;
    logic [15:0] first;
    int          n = 0;
    m = model_word(codes);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    check({tag, "_bcd"}, 32'(out_bcd), 32'(m[15:0]));
    check({tag, "_err"}, 32'(out_err), 32'(m[16]));
    first = out_bcd;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_bcd"}, 32'(out_bcd), 32'(first));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_consumed"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
`ifdef EX3_ERR_COUNT_EN
    check({tag, "_err_cnt"}, 32'(err_cnt), (inv_total > 255) ? 32'd255 : 32'(inv_total));
`endif
  endtask

  initial begin
    logic [15:0] w;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
`ifdef EX3_ERR_COUNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    #1 check("release_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("post_release_in_ready", 32'(in_ready), 32'd1);

    // Basic word, downstream always ready: one-cycle out_valid pulse
    out_ready = 1'b1;
    send_word(16'h4567, 0);
    expect_word("t1", 16'h4567, 0);

    // Sweep of every legal code across three words
    send_word(16'h3456, 0);
    expect_word("t2a", 16'h3456, 0);
    send_word(16'h789A, 1);
    expect_word("t2b", 16'h789A, 0);
    w = {8'hBC, 8'h34};
    send_word(w, 0);
    expect_word("t2c", w, 0);

    // Invalid codes flag the word, next word is clean
    send_word(16'h3CF3, 0);
    expect_word("t3a", 16'h3CF3, 0);
    send_word(16'h4444, 0);
    expect_word("t3b", 16'h4444, 0);

    // Backpressure: a digit is offered while held and must not be taken
    send_word(16'h5A3C, 0);
    in_valid = 1'b1;
    in_ex3   = 4'h5;
    expect_word("t4", 16'h5A3C, 5);
    send_word(16'h6789, 0);
    expect_word("t4_next", 16'h6789, 0);

    // Reset mid-word discards the partial word
    send_digit(4'h7);
    send_digit(4'h8);
    #2 rst = 1'b1;
    #1;
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_bcd", 32'(out_bcd), 32'd0);
    check("t5_out_err", 32'(out_err), 32'd0);
`ifdef EX3_ERR_COUNT_EN
    check("t5_err_cnt", 32'(err_cnt), 32'd0);
    inv_total = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_word(16'hCCCC, 0);
    expect_word("t5_word", 16'hCCCC, 0);

    // Randomized words with gaps and backpressure
    for (int k = 0; k < 24; k++) begin
      w = 16'($urandom);
      send_word(w, $urandom_range(0, 2));
      expect_word("rand", w, $urandom_range(0, 3));
    end

`ifdef EX3_ERR_COUNT_EN
    // 300 invalid digits drive the counter into saturation
    for (int k = 0; k < 75; k++) begin
      send_word(16'h0000, 0);
      expect_word("t6", 16'h0000, 0);
    end
    check("t6_saturated", 32'(err_cnt), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
